// File: rtl/nbit_down_timer.sv
// rtl/nbit_down_timer.sv - N-bit loadable down-timer with one-shot/auto-reload and terminal-count pulse
// Counts from the loaded value down to 1; the step out of 1 pulses tc and either reloads or ends at 0.
module nbit_down_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic         reload,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ZERO = '0;

  state_t       state, state_n;
  logic [N-1:0] count_n;
  logic [N-1:0] reload_val, reload_val_n;
  logic         tc_n;
  logic         load_nz;

  assign load_nz = (load_val != ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_val <= ZERO;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_val <= reload_val_n;
      tc         <= tc_n;
      busy       <= (state_n == RUN);
    end
  end

  // Priority within RUN: stop, then start (restart or abort-to-zero), then decrement.
  always_comb begin
    state_n      = state;
    count_n      = count;
    reload_val_n = reload_val;
    tc_n         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && load_nz) begin
          count_n      = load_val;
          reload_val_n = load_val;
          state_n      = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start) begin
          if (load_nz) begin
            count_n      = load_val;
            reload_val_n = load_val;
          end else begin
            count_n = ZERO;
            state_n = IDLE;
          end
        end else if (en) begin
          if (count > ONE) begin
            count_n = count - ONE;
          end else begin
            // Terminal step: count is 1 here, never 0, since RUN is only entered with a nonzero load.
            tc_n = 1'b1;
            if (reload) begin
              count_n = reload_val;
            end else begin
              count_n = ZERO;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nbit_down_timer.sv
// tb/tb_nbit_down_timer.sv - vector table plus scoreboard bench for nbit_down_timer
module tb_nbit_down_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, start = 1'b0, stop = 1'b0, reload = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count;
  logic       tc, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en, start, stop, reload;
    logic [3:0] load_val;
    logic [3:0] exp_count;
    logic       exp_tc, exp_busy;
  } vec_t;

  typedef struct {
    logic [3:0] count;
    logic       tc, busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  nbit_down_timer #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
    .reload(reload), .load_val(load_val), .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic e, s, p, r, input logic [3:0] lv,
                              input logic [3:0] ec, input logic et, eb);
    vec_t v;
    v.en = e; v.start = s; v.stop = p; v.reload = r; v.load_val = lv;
    v.exp_count = ec; v.exp_tc = et; v.exp_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    en = v.en; start = v.start; stop = v.stop; reload = v.reload; load_val = v.load_val;
    e.count = v.exp_count; e.tc = v.exp_tc; e.busy = v.exp_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_count"}, int'(count), int'(e.count));
      chk({tag, "_tc"},    int'(tc),    int'(e.tc));
      chk({tag, "_busy"},  int'(busy),  int'(e.busy));
    end
  endtask

  initial begin
    // en, start, stop, reload, load_val -> count, tc, busy
    // one-shot 5
    vecs.push_back(mk(1,1,0,0, 5,  5,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  4,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  3,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  2,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  1,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  0,1,0));
    vecs.push_back(mk(1,0,0,0, 0,  0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,  0,0,0));
    // enable gaps, load 4
    vecs.push_back(mk(0,1,0,0, 4,  4,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  3,0,1));
    vecs.push_back(mk(0,0,0,0, 0,  3,0,1));
    vecs.push_back(mk(0,0,0,0, 0,  3,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  2,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  1,0,1));
    vecs.push_back(mk(0,0,0,0, 0,  1,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  0,1,0));
    // auto-reload 3, started on the edge right after a one-shot tc
    vecs.push_back(mk(0,1,0,1, 3,  3,0,1));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1,0,0,1, 0,  2,0,1));
      vecs.push_back(mk(1,0,0,1, 0,  1,0,1));
      vecs.push_back(mk(1,0,0,1, 0,  3,1,1));
    end
    vecs.push_back(mk(1,0,0,0, 0,  2,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  1,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  0,1,0));
    // zero load ignored in IDLE
    vecs.push_back(mk(1,1,0,0, 0,  0,0,0));
    // restart at count 1 with en, then stop at 6
    vecs.push_back(mk(0,1,0,0, 2,  2,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  1,0,1));
    vecs.push_back(mk(1,1,0,0, 9,  9,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  8,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  7,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  6,0,1));
    vecs.push_back(mk(1,0,1,0, 0,  6,0,0));
    vecs.push_back(mk(1,0,1,0, 0,  6,0,0));
    // stop beats start
    vecs.push_back(mk(0,1,0,0, 3,  3,0,1));
    vecs.push_back(mk(1,1,1,0, 7,  3,0,0));
    // stop at count 1 with en: no tc
    vecs.push_back(mk(0,1,0,0, 2,  2,0,1));
    vecs.push_back(mk(1,0,0,0, 0,  1,0,1));
    vecs.push_back(mk(1,0,1,0, 0,  1,0,0));
    // start with zero load in RUN aborts to 0
    vecs.push_back(mk(0,1,0,0, 5,  5,0,1));
    vecs.push_back(mk(1,1,0,0, 0,  0,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_tc",    int'(tc),    0);
    chk("reset_busy",  int'(busy),  0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // full-scale load: 15 enabled edges to tc, no wrap
    step(mk(0,1,0,0, 15, 15,0,1), "max_load");
    for (int j = 14; j >= 1; j--) step(mk(1,0,0,0, 0, 4'(j),0,1), $sformatf("max_dec%0d", j));
    step(mk(1,0,0,0, 0,  0,1,0), "max_tc");
    step(mk(1,0,0,0, 0,  0,0,0), "max_after");

    // asynchronous reset mid-run at count 7
    step(mk(0,1,0,0, 9,  9,0,1), "rst_load");
    step(mk(1,0,0,0, 0,  8,0,1), "rst_dec8");
    step(mk(1,0,0,0, 0,  7,0,1), "rst_dec7");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_tc",    int'(tc),    0);
    chk("async_rst_busy",  int'(busy),  0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1,0,0,1, 0,  0,0,0), "post_rst_idle0");
    step(mk(1,0,0,1, 0,  0,0,0), "post_rst_idle1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nbit_down_timer.md
# nbit_down_timer

Parameterized N-bit loadable down-counter/timer with enable, one-shot or auto-reload mode, and a terminal-count pulse. It counts in the opposite direction to the N-bit up-counter. It is loaded with a value, decrements on enabled clocks, and reports expiry. It is used wherever a block needs a programmable delay or a periodic tick.

## Interface
- `N`, default 4, counter width in bits.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: decrement enable, sampled each rising edge while running.
- `start` input 1: load-and-run request, sampled each rising edge.
- `stop` input 1: abort request, sampled each rising edge.
- `reload` input 1: mode select, sampled at every terminal count. 1 means auto-reload; 0 means one-shot.
- `load_val` input N: start value, sampled on an accepted `start`.
- `count` output N: current counter value (registered).
- `tc` output 1: terminal-count pulse, exactly one cycle wide (registered).
- `busy` output 1: high while in RUN (registered).

## Operation
- Internal state:
  - Two-state FSM: IDLE and RUN.
  - N-bit `reload_val` register, holding the last accepted `load_val`.
- Reset (`rst_n` low, any time, asynchronous):
  - State becomes IDLE.
  - `count`, `reload_val`, `tc` and `busy` all become 0.
  - Reset mid-count discards the run; there is no pending `tc`.
- `tc` defaults to 0 on every edge unless a rule below sets it to 1.
- Priority per edge: `stop` > `start` > decrement.
- IDLE:
  - `start` with `load_val` ≠ 0: `count` ← `load_val`, `reload_val` ← `load_val`, go to RUN.
  - `start` with `load_val` = 0: ignored. Stay in IDLE, `count` unchanged, no `tc`.
  - `en` and `stop` have no effect; `count` holds.
- RUN:
  - `stop`: go to IDLE, `count` holds its present value, no `tc`. This applies even if `start` or `en` is also high.
  - `start` (no `stop`), `load_val` ≠ 0: restart. `count` ← `load_val`, `reload_val` ← `load_val`, stay in RUN, no `tc`, even if `count` = 1 and `en` = 1.
  - `start` (no `stop`), `load_val` = 0: go to IDLE, `count` ← 0, no `tc`.
  - `en` = 0: `count` holds.
  - `en` = 1 and `count` > 1: `count` ← `count` − 1.
  - `en` = 1, `count` = 1, `reload` = 1: `count` ← `reload_val`, `tc` ← 1, stay in RUN. The value 0 is never presented.
  - `en` = 1, `count` = 1, `reload` = 0: `count` ← 0, `tc` ← 1, go to IDLE.
- `count` never underflows or wraps past 0. `count` = 0 in RUN is unreachable.
- `busy` = 1 exactly when the state is RUN.
- Arithmetic is unsigned N-bit. The maximum load is 2^N − 1.

## Timing
- Start latency: `start` sampled at edge k gives `count` = L and `busy` = 1 after edge k.
- With `en` held high from edge k+1:
  - `count` = L − j after edge k+j.
  - `tc` = 1 after edge k+L, for one cycle only.
- One-shot: `busy` falls on the same edge that `tc` rises, and `count` = 0 alongside it.
- Auto-reload:
  - Period is L enabled edges.
  - `tc` pulses every L enabled cycles.
  - `busy` stays 1.
- `en` low cycles stretch the delay one-for-one; there is no lost or extra decrement.
- A mode change on `reload` takes effect at the next terminal count.
- A new `start` can be accepted on the edge immediately after a one-shot `tc`.

## Test plan
- Reset: assert `rst_n` = 0 mid-run at `count` = 7 (N = 4). `count`, `tc` and `busy` go to 0 asynchronously, before the next edge. After release, the block stays in IDLE until `start`.
- One-shot: `load_val` = 5, `reload` = 0, `en` = 1. `count` reads 5, 4, 3, 2, 1, 0. Single `tc` pulse together with `count` = 0; `busy` falls on the same edge. Further `en` cycles leave `count` = 0.
- Enable gaps: `load_val` = 4, `en` pattern 1,0,0,1,1,0,1. `count` reads 4, 3, 3, 3, 2, 1, 1, 0. `tc` fires only at the final step.
- Auto-reload: `load_val` = 3, `reload` = 1, `en` = 1 for 9 cycles. `count` reads 3, 2, 1, 3, 2, 1, 3, 2, 1, 3. `tc` pulses at each 1→3 step, 3 pulses in total. Drop `reload` to 0: the next terminal count ends at 0 in IDLE.
- Boundaries: `start` with `load_val` = 0 in IDLE is ignored (`busy` stays 0). `load_val` = 15 counts 15 cycles to `tc` with no wrap. `start` with `load_val` = 9 at `count` = 1 with `en` = 1 gives `count` = 9 and no `tc`.
- Stop: `stop` at `count` = 6 gives IDLE with `count` held at 6 and no `tc`. `stop` and `start` together in RUN: `stop` wins. `stop` at `count` = 1 with `en` = 1 produces no `tc`.
